p4_mp_add_ctrl: RTL and testbench

P4_MP_ADD_CTRL -- requirements
Module: p4_mp_add_ctrl

---
 rtl/p4_mp_add_ctrl.sv | 134 +++++++++++++
 tb/tb_p4_mp_add_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_mp_add_ctrl.sv
// Multi-precision add controller for the P4 adder.
// Streams operand words (least significant first) through an external
// combinational P4 adder and chains the carry from word to word.
// Two-stage pipeline: S1 holds the operand registers that drive the adder;
// S2 captures the adder result and presents it downstream.

package p4_adder_pkg;
    localparam int nbit = 32;
endpackage

module p4_mp_add_ctrl #(
    parameter int NBIT   = p4_adder_pkg::nbit,
    parameter int NWORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] in_a,
    input  logic [NBIT-1:0] in_b,
    input  logic            in_cin,
    input  logic            in_last,
    output logic [NBIT-1:0] add_a,
    output logic [NBIT-1:0] add_b,
    output logic            add_cin,
    input  logic [NBIT-1:0] add_s,
    input  logic            add_cout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] out_s,
    output logic            out_last,
    output logic            out_cout,
    output logic [7:0]      out_idx,
    output logic            len_err
);

    // Index of the last word an operand may have before it is cut short.
    localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t     state;
    logic       s1_valid;
    logic       s1_last;
    logic [7:0] s1_idx;
    logic [7:0] word_cnt;
    logic       carry_q;

    logic       s1_advance;
    logic       in_xfer;
    logic       out_xfer;
    logic [7:0] cur_idx;
    logic       forced_last;
    logic       eff_last;
    logic       sel_cin;

    // Handshake, word indexing and carry selection for the incoming word.
    // The carry comes from the adder live while the previous word still sits
    // in S1; once that word has moved on, the copy saved in carry_q is used.
    always_comb begin
        s1_advance  = s1_valid && (!out_valid || out_ready);
        in_ready    = !s1_valid || s1_advance;
        in_xfer     = in_valid && in_ready;
        out_xfer    = out_valid && out_ready;
        cur_idx     = (state == IDLE) ? 8'd0 : word_cnt;
        forced_last = !in_last && (cur_idx == LAST_IDX);
        eff_last    = in_last || forced_last;
        sel_cin     = in_cin;
        if (state == RUN) begin
            sel_cin = s1_valid ? add_cout : carry_q;
        end
    end

    // The S2 carry is only reported on the final word of an operand.
    assign out_cout = carry_q & out_last;

    // S1 operand register and operand-framing FSM; an overlong operand is
    // closed at the maximum word count and the following word starts afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= 8'd0;
            word_cnt <= 8'd0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            if (in_xfer) begin
                add_a    <= in_a;
                add_b    <= in_b;
                add_cin  <= sel_cin;
                s1_valid <= 1'b1;
                s1_last  <= eff_last;
                s1_idx   <= cur_idx;
                word_cnt <= eff_last ? 8'd0 : cur_idx + 8'd1;
                state    <= eff_last ? IDLE : RUN;
                if (forced_last) begin
                    len_err <= 1'b1;
                end
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2 result register; holds steady under backpressure and keeps the
    // word's carry so a later word can still chain from it after a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_last  <= 1'b0;
            out_idx   <= 8'd0;
            carry_q   <= 1'b0;
        end else begin
            if (s1_advance) begin
                out_valid <= 1'b1;
                out_s     <= add_s;
                out_last  <= s1_last;
                out_idx   <= s1_idx;
                carry_q   <= add_cout;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_p4_mp_add_ctrl.sv
// Directed testbench for p4_mp_add_ctrl with a behavioural P4 adder.
// Expected result words are hand computed and queued before each operand.

module tb_p4_mp_add_ctrl;

    localparam int NBIT   = 32;
    localparam int NWORDS = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] in_a;
    logic [NBIT-1:0] in_b;
    logic            in_cin;
    logic            in_last;
    logic [NBIT-1:0] add_a;
    logic [NBIT-1:0] add_b;
    logic            add_cin;
    logic [NBIT-1:0] add_s;
    logic            add_cout;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] out_s;
    logic            out_last;
    logic            out_cout;
    logic [7:0]      out_idx;
    logic            len_err;

    typedef struct packed {
        logic [31:0] s;
        logic        last;
        logic        cout;
        logic [7:0]  idx;
    } exp_t;

    exp_t expq[$];
    int   outTimes[$];
    int   vectors;
    int   miscompares;
    int   cycle;
    int   stall;
    int   notReady;

    p4_mp_add_ctrl #(
        .NBIT   (NBIT),
        .NWORDS (NWORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_idx   (out_idx),
        .len_err   (len_err)
    );

    // Behavioural stand-in for the combinational P4 adder.
    logic [NBIT:0] sumFull;
    assign sumFull  = {1'b0, add_a} + {1'b0, add_b} + {{NBIT{1'b0}}, add_cin};
    assign add_s    = sumFull[NBIT-1:0];
    assign add_cout = sumFull[NBIT];

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic last);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_last  = last;
    endtask

    function automatic void pushExp(input logic [31:0] s, input logic last, input logic cout,
                                    input logic [7:0] idx);
        exp_t e;
        e.s    = s;
        e.last = last;
        e.cout = cout;
        e.idx  = idx;
        expq.push_back(e);
    endfunction

    // One cycle starting at a negedge: set out_ready, observe handshakes
    // shortly after, check any output word about to transfer, then advance.
    task automatic tickCycle(output bit acc);
        exp_t e;
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = 1'b1;
        end
        #1;
        acc = in_valid && in_ready;
        if (!in_ready) notReady++;
        if (out_valid && out_ready) begin
            outTimes.push_back(cycle);
            if (expq.size() == 0) begin
                checkOutput("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("out_s", out_s, e.s);
                checkOutput("out_last", {31'd0, out_last}, {31'd0, e.last});
                checkOutput("out_cout", {31'd0, out_cout}, {31'd0, e.cout});
                checkOutput("out_idx", {24'd0, out_idx}, {24'd0, e.idx});
            end
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
        bit acc;
        int n;
        applyStimulus(1'b1, a, b, cin, last);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tickCycle(acc);
            n++;
        end
        checkOutput("word_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tickCycle(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n = 0;
        while (expq.size() > 0 && n < 50) begin
            tickCycle(acc);
            n++;
        end
        checkOutput("drain_empty", expq.size(), 32'd0);
        tickCycle(acc);
    endtask

    // Directed sequence covering reset, streaming, stalls, gaps, overlength
    // and reset in the middle of an operand.
    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        stall       = 0;
        notReady    = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        #2;
        $display("[TB] reset values");
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_add_a", add_a, 32'd0);
        checkOutput("rst_add_cin", {31'd0, add_cin}, 32'd0);
        checkOutput("rst_out_s", out_s, 32'd0);
        checkOutput("rst_out_idx", {24'd0, out_idx}, 32'd0);
        checkOutput("rst_len_err", {31'd0, len_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single word with latency check");
        pushExp(32'h0000_0000, 1'b1, 1'b1, 8'd0);
        sendWord(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        checkOutput("lat1_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("lat1_add_a", add_a, 32'hFFFF_FFFF);
        checkOutput("lat1_add_b", add_b, 32'h0000_0001);
        idleCycles(1);
        checkOutput("lat2_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("lat2_out_s", out_s, 32'd0);
        checkOutput("lat2_out_cout", {31'd0, out_cout}, 32'd1);
        checkOutput("lat2_out_last", {31'd0, out_last}, 32'd1);
        drain();

        $display("[TB] four-word back-to-back");
        outTimes.delete();
        notReady = 0;
        pushExp(32'h0, 1'b0, 1'b0, 8'd0);
        pushExp(32'h0, 1'b0, 1'b0, 8'd1);
        pushExp(32'h0, 1'b0, 1'b0, 8'd2);
        pushExp(32'h0, 1'b1, 1'b1, 8'd3);
        sendWord(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        sendWord(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        sendWord(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        sendWord(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        checkOutput("b2b_in_ready_low", notReady, 32'd0);
        drain();
        checkOutput("b2b_out_count", outTimes.size(), 32'd4);
        if (outTimes.size() == 4) begin
            checkOutput("b2b_consecutive", outTimes[3] - outTimes[0], 32'd3);
        end

        $display("[TB] backpressure mid-operand");
        pushExp(32'h0000_0001, 1'b0, 1'b0, 8'd0);
        pushExp(32'h2345_678A, 1'b0, 1'b0, 8'd1);
        pushExp(32'hFFFF_FFFF, 1'b0, 1'b0, 8'd2);
        pushExp(32'h0000_0000, 1'b1, 1'b1, 8'd3);
        sendWord(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        sendWord(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        stall    = 3;
        notReady = 0;
        sendWord(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        checkOutput("bp_in_ready_dropped", notReady, 32'd3);
        sendWord(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        drain();

        $display("[TB] input gap uses saved carry");
        pushExp(32'h0000_0000, 1'b0, 1'b0, 8'd0);
        pushExp(32'h0000_0001, 1'b1, 1'b0, 8'd1);
        sendWord(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idleCycles(2);
        sendWord(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
        drain();
        checkOutput("len_err_clear", {31'd0, len_err}, 32'd0);

        $display("[TB] overlength operand");
        pushExp(32'h0000_0000, 1'b0, 1'b0, 8'd0);
        pushExp(32'h0000_0001, 1'b0, 1'b0, 8'd1);
        pushExp(32'h0000_000B, 1'b0, 1'b0, 8'd2);
        pushExp(32'hFFFF_FFFE, 1'b1, 1'b1, 8'd3);
        pushExp(32'h0000_0030, 1'b0, 1'b0, 8'd0);
        pushExp(32'h0000_0000, 1'b1, 1'b0, 8'd1);
        sendWord(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        sendWord(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        sendWord(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
        sendWord(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("len_err_set", {31'd0, len_err}, 32'd1);
        sendWord(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        sendWord(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        drain();
        checkOutput("len_err_sticky", {31'd0, len_err}, 32'd1);

        $display("[TB] reset mid-operand");
        sendWord(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        sendWord(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_add_a", add_a, 32'd0);
        checkOutput("mid_rst_add_b", add_b, 32'd0);
        checkOutput("mid_rst_out_s", out_s, 32'd0);
        checkOutput("mid_rst_out_idx", {24'd0, out_idx}, 32'd0);
        checkOutput("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        checkOutput("mid_rst_len_err", {31'd0, len_err}, 32'd0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pushExp(32'h0000_0000, 1'b1, 1'b1, 8'd0);
        sendWord(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
